ahb_ext_mem_subordinate: RTL and testbench
==========================================

// Module: ahb_ext_mem_subordinate
// PURPOSE
//  AHB-Lite subordinate that terminates the SoC's external-memory manager port (HSELEXT/HADDR/HWDATA...)
//  on an FPGA block RAM. Accepts pipelined single transfers, inserts WAITSTATES wait cycles,
//  applies HWSTRB byte enables, and returns a two-cycle ERROR for out-of-range or oversize transfers.
//  Sits in the FPGA top level between the SoC wrapper and a single-port synchronous RAM.
// PARAMETERS
//  AHBW       64            data bus width, bits (32 or 64)
//  PA_BITS    56            physical address width
//  BASE       'h8000_0000   byte base address of the window
//  MEM_WORDS  65536         RAM depth in AHBW-bit words (power of 2); AW = $clog2(MEM_WORDS)
//  WAITSTATES 0             extra data-phase wait cycles per transfer (0..15)
// PORTS
//  clk        in   1         clock (HCLK)
//  reset      in   1         synchronous, active-high reset
//  HSEL       in   1         subordinate select (from HSELEXT)
//  HADDR      in   PA_BITS   byte address
//  HTRANS     in   2         IDLE/BUSY/NONSEQ/SEQ; only HTRANS[1]=1 starts a transfer
//  HWRITE     in   1         1 = write
//  HSIZE      in   3         log2 bytes of transfer
//  HWDATA     in   AHBW      write data, valid in data phase
//  HWSTRB     in   AHBW/8    write byte strobes, valid in data phase
//  HREADY     in   1         bus-level ready (previous transfer complete)
//  HREADYOUT  out  1         this subordinate's data-phase ready
//  HRESP      out  1         0 OKAY, 1 ERROR
//  HRDATA     out  AHBW      read data, valid when HREADYOUT=1 in a read data phase; 0 otherwise
//  MemEn      out  1         RAM enable (read or write)
//  MemWe      out  AHBW/8    RAM byte write enables
//  MemAddr    out  AW        RAM word address = (HADDR-BASE) >> $clog2(AHBW/8)
//  MemWData   out  AHBW      RAM write data
//  MemRData   in   AHBW      RAM read data; 1-cycle latency, held until next MemEn
// BEHAVIOUR
//  - Reset: HREADYOUT=1, HRESP=0, HRDATA=0, MemEn=0, MemWe=0, state IDLE, wait counter 0.
//  - Accept = HSEL & HREADY & HTRANS[1]. On accept, register HADDR/HWRITE/HSIZE (data-phase regs).
//  - Error check at accept: (HADDR-BASE) >= MEM_WORDS*AHBW/8 (unsigned) or HSIZE > $clog2(AHBW/8).
//  - States: IDLE, RDWAIT, WRWAIT, RAWSTALL, ERR1, ERR2.
//  - IDLE: accept OK read -> MemEn=1, MemAddr from HADDR in same cycle; go RDWAIT, count=WAITSTATES.
//    accept OK write -> WRWAIT, count=WAITSTATES. accept bad -> ERR1. no accept -> IDLE.
//  - RDWAIT/WRWAIT: HREADYOUT=0 while count>0, decrement each cycle; count==0 -> HREADYOUT=1.
//    Read final cycle: HRDATA=MemRData. Write final cycle: MemEn=1, MemWe=HWSTRB, MemAddr=registered,
//    MemWData=HWDATA. No RAM write in any earlier cycle. Data phase = 1+WAITSTATES cycles.
//  - Final cycle is also an address phase: a new accept there follows the IDLE rules (back-to-back,
//    zero bubble), except the port-conflict case below.
//  - Read accepted in a write's final cycle (single RAM port busy): read not issued; -> RAWSTALL
//    (HREADYOUT=0, MemEn=1, MemAddr=registered read address), then RDWAIT with count=WAITSTATES.
//    Read data phase = 2+WAITSTATES; read returns the just-written bytes.
//  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1; accept in ERR2 handled as in IDLE.
//    No MemEn/MemWe for errored transfers. HTRANS changes during ERR1 are ignored.
//  - HRESP=0 in all non-ERR states. BUSY/IDLE HTRANS with HSEL -> OKAY zero-wait, no RAM access.
//  - HSEL low with HREADY high: no accept; in-flight data phase completes regardless of HSEL.
//  - reset mid-transfer: return to reset values next cycle; a pending write is dropped (no MemWe).
//  - Address offset wrap: subtraction is PA_BITS-bit unsigned; HADDR<BASE wraps large -> ERROR.
// TESTING
//  W=0: write 0x1122334455667788 @BASE+8, HWSTRB=0xFF; read BASE+8 -> one-cycle data phases, same data.
//  W=2: read BASE -> HREADYOUT low 2 cycles then high with MemRData; MemEn exactly once.
//  Write BASE+0 strobe 0x0F data all 0xAA, then immediate read BASE+0 -> RAWSTALL 1 cycle,
//    read shows low 4 bytes 0xAA, upper bytes unchanged.
//  Read BASE+MEM_WORDS*8 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1; no MemEn.
//  HSIZE=3'b100 on AHBW=64 -> same 2-cycle ERROR; next NONSEQ accepted in ERR2 completes OKAY.
//  W=3: assert reset in 2nd wait cycle of a write -> outputs at reset values, MemWe never asserted.

Source files
------------

// File: rtl/ahb_ext_mem_subordinate_if.sv
// AHB-Lite bus bundle between the SoC external-memory manager port and the
// block-RAM subordinate. The manager side drives the address/data phase
// signals plus the bus-level HREADY; the subordinate returns its own ready,
// response and read data.
interface ahb_ext_mem_subordinate_if #(
    parameter int AHBW    = 64,
    parameter int PA_BITS = 56
);
    logic                HSEL;
    logic [PA_BITS-1:0]  HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [AHBW-1:0]     HWDATA;
    logic [AHBW/8-1:0]   HWSTRB;
    logic                HREADY;
    logic                HREADYOUT;
    logic                HRESP;
    logic [AHBW-1:0]     HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_ext_mem_subordinate.sv
// AHB-Lite subordinate terminating the external-memory window on a
// single-port synchronous block RAM (1-cycle read latency).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no data phase in flight; address phase open
// RDWAIT   | read data phase; counts down wait cycles, returns RAM data at 0
// WRWAIT   | write data phase; counts down, writes RAM on the final cycle
// RAWSTALL | read accepted while the RAM port was busy writing; issue it now
// ERR1     | first ERROR cycle (HREADYOUT low)
// ERR2     | second ERROR cycle (HREADYOUT high); address phase open
module ahb_ext_mem_subordinate #(
    parameter int                 AHBW       = 64,
    parameter int                 PA_BITS    = 56,
    parameter logic [PA_BITS-1:0] BASE       = 'h8000_0000,
    parameter int                 MEM_WORDS  = 65536,
    parameter int                 WAITSTATES = 0,
    localparam int                AW         = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    ahb_ext_mem_subordinate_if.slave ahb,
    output logic                  MemEn,
    output logic [AHBW/8-1:0]     MemWe,
    output logic [AW-1:0]         MemAddr,
    output logic [AHBW-1:0]       MemWData,
    input  logic [AHBW-1:0]       MemRData
);
    localparam int                 SZ    = $clog2(AHBW/8);
    localparam logic [PA_BITS:0]   LIMIT = (PA_BITS+1)'(MEM_WORDS) << SZ;
    localparam logic [3:0]         WS    = 4'(WAITSTATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDWAIT,
        ST_WRWAIT,
        ST_RAWSTALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;

    logic [PA_BITS-1:0] offset;
    logic [AW-1:0]      acc_word;
    logic               accept;
    logic               acc_bad;
    logic               addr_phase;
    logic               raw_conflict;
    logic               hreadyout;
    logic               hresp;
    logic [AHBW-1:0]    hrdata;
    logic               unused_htrans;

    // Offset wraps modulo 2^PA_BITS, so addresses below BASE land out of range.
    assign offset        = ahb.HADDR - BASE;
    assign acc_word      = offset[SZ +: AW];
    assign accept        = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign acc_bad       = ({1'b0, offset} >= LIMIT) || (int'(ahb.HSIZE) > SZ);
    assign unused_htrans = ahb.HTRANS[0];

    assign ahb.HREADYOUT = hreadyout;
    assign ahb.HRESP     = hresp;
    assign ahb.HRDATA    = hrdata;
    assign MemWData      = ahb.HWDATA;

    // State, wait down-counter and registered word address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next state, bus response and RAM port control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        hreadyout    = 1'b1;
        hresp        = 1'b0;
        hrdata       = '0;
        MemEn        = 1'b0;
        MemWe        = '0;
        MemAddr      = addr_q;
        addr_phase   = 1'b0;
        raw_conflict = 1'b0;

        unique case (state_q)
            ST_IDLE: addr_phase = 1'b1;
            ST_RDWAIT: begin
                if (cnt_q != 4'd0) begin
                    hreadyout = 1'b0;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    hrdata     = MemRData;
                    addr_phase = 1'b1;
                end
            end
            ST_WRWAIT: begin
                if (cnt_q != 4'd0) begin
                    hreadyout = 1'b0;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    MemEn        = 1'b1;
                    MemWe        = ahb.HWSTRB;
                    addr_phase   = 1'b1;
                    raw_conflict = 1'b1;
                end
            end
            ST_RAWSTALL: begin
                hreadyout = 1'b0;
                MemEn     = 1'b1;
                state_d   = ST_RDWAIT;
                cnt_d     = WS;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp      = 1'b1;
                addr_phase = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // The RAM port is taken by the write in its final cycle, so a read
        // accepted there is deferred one cycle through RAWSTALL.
        if (addr_phase) begin
            state_d = ST_IDLE;
            if (accept) begin
                addr_d = acc_word;
                cnt_d  = WS;
                if (acc_bad) begin
                    state_d = ST_ERR1;
                end else if (ahb.HWRITE) begin
                    state_d = ST_WRWAIT;
                end else if (raw_conflict) begin
                    state_d = ST_RAWSTALL;
                end else begin
                    state_d = ST_RDWAIT;
                    MemEn   = 1'b1;
                    MemAddr = acc_word;
                end
            end
        end

        // A write pending when reset arrives must never reach the RAM.
        if (reset) begin
            MemEn = 1'b0;
            MemWe = '0;
        end
    end
endmodule

// File: tb/tb_ahb_ext_mem_subordinate.sv
`timescale 1ns/1ps
module tb_ahb_ext_mem_subordinate;
    localparam int AHBW = 64, PA_BITS = 56, MEM_WORDS = 1024, AW = 10, N = 3;
    localparam logic [PA_BITS-1:0] BASE = 56'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst    [N];
    logic               hsel   [N];
    logic [PA_BITS-1:0] haddr  [N];
    logic [1:0]         htrans [N];
    logic               hwrite [N];
    logic [2:0]         hsize  [N];
    logic [63:0]        hwdata [N];
    logic [7:0]         hwstrb [N];
    logic               hro    [N];
    logic               hresp  [N];
    logic [63:0]        hrdata [N];
    logic               memen  [N];
    logic [7:0]         memwe  [N];

    int checks = 0, errors = 0;

    // Instance 0: no wait states, 1: two, 2: three.
    for (genvar g = 0; g < N; g++) begin : gen_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        ahb_ext_mem_subordinate_if #(.AHBW(AHBW), .PA_BITS(PA_BITS)) bus ();
        logic          mem_en;
        logic [7:0]    mem_we;
        logic [AW-1:0] mem_addr;
        logic [63:0]   mem_wdata, mem_rdata;
        logic [63:0]   ram [MEM_WORDS];
        int            en_cnt = 0, we_cnt = 0;

        assign bus.HSEL   = hsel[g];
        assign bus.HADDR  = haddr[g];
        assign bus.HTRANS = htrans[g];
        assign bus.HWRITE = hwrite[g];
        assign bus.HSIZE  = hsize[g];
        assign bus.HWDATA = hwdata[g];
        assign bus.HWSTRB = hwstrb[g];
        assign bus.HREADY = bus.HREADYOUT;
        assign hro[g]     = bus.HREADYOUT;
        assign hresp[g]   = bus.HRESP;
        assign hrdata[g]  = bus.HRDATA;
        assign memen[g]   = mem_en;
        assign memwe[g]   = mem_we;

        ahb_ext_mem_subordinate #(
            .AHBW(AHBW), .PA_BITS(PA_BITS), .BASE(BASE),
            .MEM_WORDS(MEM_WORDS), .WAITSTATES(WS)
        ) u_dut (
            .clk(clk), .reset(rst[g]), .ahb(bus),
            .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr),
            .MemWData(mem_wdata), .MemRData(mem_rdata)
        );

        initial for (int i = 0; i < MEM_WORDS; i++) ram[i] = 64'hF0E0D0C0B0A09080 | 64'(i);

        always @(posedge clk) begin
            if (mem_en) begin
                mem_rdata <= ram[mem_addr];
                for (int b = 0; b < 8; b++)
                    if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                en_cnt <= en_cnt + 1;
                if (mem_we != 8'h00) we_cnt <= we_cnt + 1;
            end
        end
    end

    typedef struct { logic [PA_BITS-1:0] addr; bit wr; logic [2:0] size; logic [63:0] wd; logic [7:0] st; } xf_t;
    typedef struct { int inst; bit err; int waits; logic [63:0] data; } exp_t;
    xf_t  xq[$];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input int k, input logic [PA_BITS-1:0] a, input bit wr, input logic [2:0] sz,
                       input logic [63:0] wd, input logic [7:0] st,
                       input bit err, input int waits, input logic [63:0] data);
        xf_t  x;
        exp_t e;
        x.addr = a; x.wr = wr; x.size = sz; x.wd = wd; x.st = st;
        xq.push_back(x);
        e.inst = k; e.err = err; e.waits = waits; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pipelined manager: address of transfer i overlaps data phase of d.
    task automatic run(input int k);
        int i = 0, d = -1, guard = 0;
        bit rdy;
        while ((i < xq.size() || d >= 0) && guard < 100) begin
            if (i < xq.size()) begin
                hsel[k] = 1'b1; htrans[k] = 2'b10; haddr[k] = xq[i].addr;
                hwrite[k] = xq[i].wr; hsize[k] = xq[i].size;
            end else begin
                hsel[k] = 1'b0; htrans[k] = 2'b00;
            end
            if (d >= 0) begin
                hwdata[k] = xq[d].wd; hwstrb[k] = xq[d].st;
            end
            @(negedge clk);
            rdy = hro[k];
            @(posedge clk);
            #1;
            guard++;
            if (rdy) begin
                d = (i < xq.size()) ? i : -1;
                if (i < xq.size()) i++;
            end
        end
        chk("run_bound", 64'(guard >= 100), 64'd0);
        xq.delete();
    endtask

    // Monitor: tracks each data phase and scores it when HREADYOUT closes it.
    bit dp [N];
    int lowc [N];
    bit firsterr [N];
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst[k]) begin
                dp[k] = 1'b0;
            end else begin
                if (dp[k]) begin
                    if (hro[k]) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_completion", 64'(k), 64'hFFFF);
                        end else begin
                            exp_t e;
                            e = sbq.pop_front();
                            chk("inst", 64'(k), 64'(e.inst));
                            chk("waits", 64'(lowc[k]), 64'(e.waits));
                            chk("hresp", 64'(hresp[k]), 64'(e.err));
                            chk("hrdata", hrdata[k], e.data);
                            if (e.err) chk("err_first_cycle_hresp", 64'(firsterr[k]), 64'd1);
                        end
                        dp[k] = 1'b0;
                    end else begin
                        if (lowc[k] == 0) firsterr[k] = hresp[k];
                        lowc[k]++;
                    end
                end
                if (hsel[k] && hro[k] && htrans[k][1]) begin
                    dp[k] = 1'b1; lowc[k] = 0; firsterr[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, w0;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = 2'b00; hwrite[k] = 1'b0;
            hsize[k] = 3'd0; hwdata[k] = '0; hwstrb[k] = '0;
        end
        cyc(3);
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_hreadyout", 64'(hro[k]), 64'd1);
            chk("rst_hresp", 64'(hresp[k]), 64'd0);
            chk("rst_hrdata", hrdata[k], 64'd0);
            chk("rst_memen", 64'(memen[k]), 64'd0);
            chk("rst_memwe", 64'(memwe[k]), 64'd0);
        end
        @(posedge clk); #1;

        // ---- W=0 ----
        add(0, BASE + 56'd8, 1, 3, 64'h1122334455667788, 8'hFF, 0, 0, 64'd0);
        run(0);
        add(0, BASE + 56'd8, 0, 3, 64'd0, 8'h00, 0, 0, 64'h1122334455667788);
        run(0);
        add(0, BASE,         0, 3, 64'd0, 8'h00, 0, 0, 64'hF0E0D0C0B0A09080);
        add(0, BASE + 56'd8, 0, 3, 64'd0, 8'h00, 0, 0, 64'h1122334455667788);
        run(0);
        add(0, BASE, 1, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 64'd0);
        add(0, BASE, 0, 3, 64'd0, 8'h00, 0, 1, 64'hF0E0D0C0AAAAAAAA);
        run(0);

        e0 = gen_dut[0].en_cnt;
        add(0, BASE + 56'h2000, 0, 3, 64'd0, 8'h00, 1, 1, 64'd0);
        add(0, BASE - 56'd8,    1, 3, 64'd0, 8'hFF, 1, 1, 64'd0);
        run(0);
        cyc(1);
        chk("err_no_memen", 64'(gen_dut[0].en_cnt - e0), 64'd0);

        add(0, BASE,          0, 3'b100, 64'd0, 8'h00, 1, 1, 64'd0);
        add(0, BASE + 56'd16, 0, 3,      64'd0, 8'h00, 0, 0, 64'hF0E0D0C0B0A09082);
        run(0);

        e0 = gen_dut[0].en_cnt;
        hsel[0] = 1'b1; haddr[0] = BASE; htrans[0] = 2'b01; hwrite[0] = 1'b1; hsize[0] = 3'd3;
        @(negedge clk);
        chk("busy_hreadyout", 64'(hro[0]), 64'd1);
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        @(negedge clk);
        chk("idle_hresp", 64'(hresp[0]), 64'd0);
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b10;
        @(negedge clk);
        chk("unsel_hreadyout", 64'(hro[0]), 64'd1);
        @(posedge clk); #1;
        htrans[0] = 2'b00; hwrite[0] = 1'b0;
        cyc(2);
        chk("nontransfer_no_memen", 64'(gen_dut[0].en_cnt - e0), 64'd0);

        // ---- W=2 ----
        e0 = gen_dut[1].en_cnt;
        add(1, BASE, 0, 3, 64'd0, 8'h00, 0, 2, 64'hF0E0D0C0B0A09080);
        run(1);
        chk("w2_memen_once", 64'(gen_dut[1].en_cnt - e0), 64'd1);
        add(1, BASE + 56'd24, 1, 3, 64'h5566778800000000, 8'hF0, 0, 2, 64'd0);
        add(1, BASE + 56'd24, 0, 3, 64'd0, 8'h00, 0, 3, 64'h55667788B0A09083);
        run(1);
        chk("w2_memwe_once", 64'(gen_dut[1].we_cnt), 64'd1);

        // ---- W=3, reset in the second wait cycle of a write ----
        hsel[2] = 1'b1; htrans[2] = 2'b10; haddr[2] = BASE + 56'd32; hwrite[2] = 1'b1; hsize[2] = 3'd3;
        cyc(1);
        hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 64'hDEADBEEFDEADBEEF; hwstrb[2] = 8'hFF;
        cyc(1);
        rst[2] = 1'b1;
        @(negedge clk);
        chk("w3_wait_hreadyout", 64'(hro[2]), 64'd0);
        chk("w3_rst_memwe_same_cycle", 64'(memwe[2]), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w3_rst_hreadyout", 64'(hro[2]), 64'd1);
        chk("w3_rst_hresp", 64'(hresp[2]), 64'd0);
        chk("w3_rst_hrdata", hrdata[2], 64'd0);
        chk("w3_rst_memen", 64'(memen[2]), 64'd0);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        cyc(6);
        w0 = gen_dut[2].we_cnt;
        chk("w3_no_memwe", 64'(w0), 64'd0);
        add(2, BASE + 56'd32, 0, 3, 64'd0, 8'h00, 0, 3, 64'hF0E0D0C0B0A09084);
        run(2);

        cyc(4);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
